apb_reg_slave: RTL
==================

# apb_reg_slave

APB completer (slave) holding the student-record register bank: group-list position, date, second name, first name, plus a read-only ID and a write counter. It is the responder for the team's APB master across the shared APB interface. It supports a parameterised number of wait states, byte strobes, and PSLVERR reporting for illegal accesses.

## Interface
- ADDR_W, 8, PADDR width; only PADDR[4:0] is decoded, upper bits must be zero or the access errors
- WAIT_STATES, 0, access-phase cycles with PREADY low before completion (0..15)
- ID_VALUE, 32'h4150_4231, contents of the read-only ID register
- PCLK  in  1  APB clock; all state updates on the rising edge
- PRESET  in  1  synchronous, active-high reset
- PSEL  in  1  completer select
- PENABLE  in  1  access-phase marker
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  ADDR_W  byte address
- PWDATA  in  32  write data
- PSTRB  in  4  write byte-lane enables; PSTRB[i] qualifies PWDATA[8i+7:8i]
- PRDATA  out  32  read data, valid only while PREADY=1 on a read
- PREADY  out  1  transfer completion
- PSLVERR  out  1  error response, valid only while PREADY=1
- pos_o, date_o, sname_o, fname_o  out  32 each  current register contents

## Operation
- Register map, 32-bit words:
  - 0x00 POS, read/write
  - 0x04 DATE, read/write
  - 0x08 SNAME, read/write
  - 0x0C FNAME, read/write
  - 0x10 ID, read-only, reads ID_VALUE
  - 0x14 WCNT, read-only, counts successful writes
- FSM states:
  - IDLE: waits for PSEL=1, PENABLE=0 (setup). Moves to ACCESS and loads the wait counter with WAIT_STATES.
  - ACCESS: while PSEL=PENABLE=1 and the counter is non-zero, decrement it. When the counter reaches 0, PREADY=1 for exactly one cycle, then go to IDLE.
  - If PSEL or PENABLE drops in ACCESS before completion (protocol violation), abort to IDLE. No register change, no error pulse.
- Address and control are captured in the setup cycle and must be stable through ACCESS. The captured values are used for decode.
- Error conditions, reported as PSLVERR=1 in the completion cycle:
  - PADDR[1:0] ≠ 0
  - address above 0x14, or any non-zero upper bit
  - write to 0x10 or 0x14
  - Any erroring write has no effect on any register or on WCNT.
- Successful writes:
  - Update only the byte lanes with PSTRB=1.
  - WCNT increments by 1, wrapping from 0xFFFF_FFFF to 0.
  - A write with PSTRB=0000 still completes OKAY and still increments WCNT.
- Reads: PRDATA = addressed register. PRDATA=0 on error, and at all times other than a read completion cycle.
- Back-to-back transfers are supported: a new setup may follow immediately after the completion cycle.

## Timing
- Reset, synchronous, while PRESET=1 at a PCLK edge:
  - FSM goes to IDLE.
  - POS, DATE, SNAME, FNAME and WCNT clear to 0.
  - PREADY, PSLVERR and PRDATA are 0.
- Reset mid-transfer: the transfer is dropped with no commit. The master must restart it.
- Setup cycle T0, then access cycles T1…
  - PREADY=1 in cycle T1+WAIT_STATES; 0 in all other cycles.
  - WAIT_STATES=0 gives the zero-wait APB transfer: 2 cycles from setup to completion.
- The register write and the WCNT update take effect at the rising edge that ends the PREADY cycle. They are visible on *_o and readable from the next transfer.
- A read of a register in the transfer immediately after a write to it returns the new value.
- PREADY, PSLVERR and PRDATA come from flops, or from a decode of flop state only. There is no combinational path from any APB input.

## Test plan
- Reset, then idle 3 cycles: PREADY=PSLVERR=0, PRDATA=0, all *_o=0. Read 0x10 → PRDATA=0x41504231, PSLVERR=0.
- WAIT_STATES=0:
  - Write 0x00=9 and 0x04="19.1" (0x31392E31), PSTRB=1111.
  - Read both back → 9 and 0x31392E31. PREADY is high exactly once per transfer, 2 cycles after setup. WCNT reads 2.
- WAIT_STATES=3:
  - Write 0x08="Panf" (0x50616E66), then read it back.
  - PREADY rises in cycle T4 of each transfer; readback is 0x50616E66.
- Strobes: FNAME=0x4D616B73 ("Maks"), then write 0xFFFFFFFF with PSTRB=0101 → readback 0x4DFF6BFF.
- Errors, each → PSLVERR=1 with no register change and WCNT unchanged:
  - write 0x14
  - write 0x18
  - read 0x02 (PRDATA=0)
  - write 0x10
- Abort and reset:
  - Drop PENABLE during a WAIT_STATES=3 write to 0x00 → POS unchanged, FSM back to IDLE.
  - Assert PRESET during the access phase of a write to 0x0C → FNAME=0, and PREADY is not asserted for that transfer.

Source files
------------

// File: rtl/apb_reg_slave.sv
// apb_reg_slave: APB completer for the student-record register bank with
// configurable wait states, byte strobes and PSLVERR on illegal accesses. Rev 1.0
`default_nettype none

module apb_reg_slave #(
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'h4150_4231
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [31:0]       PWDATA,
  input  logic [3:0]        PSTRB,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic [31:0]       pos_o,
  output logic [31:0]       date_o,
  output logic [31:0]       sname_o,
  output logic [31:0]       fname_o
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [31:0]       regs_q [4];
  logic [31:0]       wcnt_q;

  logic              capture;
  logic              done;
  logic              upper_nz;
  logic              err;
  logic              commit;
  logic [31:0]       cur_word;
  logic [31:0]       merged;
  logic [31:0]       rd_mux;

  generate
    if (ADDR_W > 5) begin : g_upper
      assign upper_nz = |addr_q[ADDR_W-1:5];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  // Decode works on the address captured at setup; addr_q[4] with a legal
  // word index means ID or WCNT, both read-only.
  assign err    = upper_nz | (addr_q[1:0] != 2'b00) | (addr_q[4:2] > 3'd5)
                | (write_q & addr_q[4]);
  assign done   = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
  assign commit = done && write_q && !err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          capture = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else if (!(PSEL && PENABLE)) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cur_word = regs_q[addr_q[3:2]];

  always_comb begin
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (strb_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (addr_q[4:2])
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = cur_word;
      3'd4:                   rd_mux = ID_VALUE;
      3'd5:                   rd_mux = wcnt_q;
      default:                rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= 32'd0;
      strb_q  <= 4'd0;
      wcnt_q  <= 32'd0;
      for (int i = 0; i < 4; i++) regs_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q  <= PADDR;
        write_q <= PWRITE;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
      end
      if (commit) begin
        regs_q[addr_q[3:2]] <= merged;
        wcnt_q              <= wcnt_q + 32'd1;
      end
    end
  end

  // Response outputs are pure decodes of flop state.
  assign PREADY  = done;
  assign PSLVERR = done && err;
  assign PRDATA  = (done && !write_q && !err) ? rd_mux : 32'd0;

  assign pos_o   = regs_q[0];
  assign date_o  = regs_q[1];
  assign sname_o = regs_q[2];
  assign fname_o = regs_q[3];

endmodule

`default_nettype wire
